// File: rtl/idli_sqi_ctrl_m.sv
// Quad-SPI (SQI) memory controller: one request per CS frame of CMD, ADDR, DUMMY (reads only) and DATA nibbles.
// Optional burst continuation (HOLD state, i_req_cont port) is enabled by defining IDLI_SQI_CTRL_BURST_EN.
module idli_sqi_ctrl_m #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int DUMMY_NIB = 2
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
`ifdef IDLI_SQI_CTRL_BURST_EN
  input  logic              i_req_cont,
`endif
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_vld,
  output logic              o_mem_sck,
  output logic              o_mem_cs,
  output logic              o_mem_io_mode,
  input  logic [3:0]        i_mem_sio,
  output logic [3:0]        o_mem_sio
);

  localparam int FW = 8 + ADDR_W + DATA_W;
  localparam logic [7:0] CMD_LAST   = 8'd1;
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIB - 1);
  localparam logic [7:0] DATA_LAST  = 8'(DATA_W / 4 - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
`ifdef IDLI_SQI_CTRL_BURST_EN
    HOLD,
`endif
    END
  } state_t;

  state_t            state;
  logic [FW-1:0]     sr;
  logic [FW-1:0]     frame;
  logic [3:0]        next_nib;
  logic [7:0]        cnt;
  logic              wr_q;
  logic [DATA_W-1:0] rx;
`ifdef IDLI_SQI_CTRL_BURST_EN
  logic              cont_q;
  logic              pend;
`endif

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic [3:0] n);
    logic [DATA_W+3:0] t;
    t = {v, n};
    return t[DATA_W-1:0];
  endfunction

  // The whole frame is shifted out of sr MSB-first: command byte, address, write data.
  assign frame    = {(i_req_wr ? 8'h02 : 8'h03), i_req_addr, i_req_data};
  assign next_nib = sr[FW-5 -: 4];

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state         <= IDLE;
      o_mem_cs      <= 1'b1;
      o_mem_sck     <= 1'b0;
      o_mem_io_mode <= 1'b0;
      o_mem_sio     <= 4'h0;
      o_rd_vld      <= 1'b0;
      o_rd_data     <= '0;
      o_req_rdy     <= 1'b0;
      sr            <= '0;
      cnt           <= 8'd0;
      wr_q          <= 1'b0;
      rx            <= '0;
`ifdef IDLI_SQI_CTRL_BURST_EN
      cont_q        <= 1'b0;
      pend          <= 1'b0;
`endif
    end else begin
      o_rd_vld <= 1'b0;
      case (state)
        IDLE: begin
          o_req_rdy <= 1'b1;
          if (i_req_vld && o_req_rdy) begin
            state         <= CMD;
            o_req_rdy     <= 1'b0;
            o_mem_cs      <= 1'b0;
            o_mem_sck     <= 1'b0;
            o_mem_io_mode <= 1'b1;
            o_mem_sio     <= frame[FW-1 -: 4];
            sr            <= frame;
            wr_q          <= i_req_wr;
            cnt           <= 8'd0;
`ifdef IDLI_SQI_CTRL_BURST_EN
            cont_q        <= i_req_cont;
`endif
          end
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (!o_mem_sck) begin
            o_mem_sck <= 1'b1;
          end else begin
            // End of phase H: sample input, advance to the next nibble slot.
            o_mem_sck <= 1'b0;
            cnt       <= cnt + 8'd1;
            sr        <= sr << 4;
            o_mem_sio <= next_nib;
            case (state)
              CMD: begin
                if (cnt == CMD_LAST) begin
                  state <= ADDR;
                  cnt   <= 8'd0;
                end
              end
              ADDR: begin
                if (cnt == ADDR_LAST) begin
                  cnt <= 8'd0;
                  if (!wr_q && (DUMMY_NIB != 0)) begin
                    state         <= DUMMY;
                    o_mem_io_mode <= 1'b0;
                    o_mem_sio     <= 4'h0;
                  end else begin
                    state         <= DATA;
                    o_mem_io_mode <= wr_q;
                    if (!wr_q) o_mem_sio <= 4'h0;
                  end
                end
              end
              DUMMY: begin
                o_mem_sio <= 4'h0;
                if (cnt == DUMMY_LAST) begin
                  state <= DATA;
                  cnt   <= 8'd0;
                end
              end
              DATA: begin
                if (!wr_q) begin
                  o_mem_sio <= 4'h0;
                  rx        <= shift_in(rx, i_mem_sio);
                end
                if (cnt == DATA_LAST) begin
                  cnt           <= 8'd0;
                  o_mem_io_mode <= 1'b0;
                  o_mem_sio     <= 4'h0;
                  if (!wr_q) begin
                    o_rd_data <= shift_in(rx, i_mem_sio);
                    o_rd_vld  <= 1'b1;
                  end
`ifdef IDLI_SQI_CTRL_BURST_EN
                  if (cont_q) begin
                    state     <= HOLD;
                    o_req_rdy <= 1'b1;
                  end else begin
                    state    <= END;
                    o_mem_cs <= 1'b1;
                  end
`else
                  state    <= END;
                  o_mem_cs <= 1'b1;
`endif
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
`ifdef IDLI_SQI_CTRL_BURST_EN
        HOLD: begin
          if (i_req_vld && o_req_rdy) begin
            o_req_rdy <= 1'b0;
            cont_q    <= i_req_cont;
            if (i_req_wr == wr_q) begin
              // Same direction: continue sequentially with only the data phase.
              state         <= DATA;
              cnt           <= 8'd0;
              sr            <= {i_req_data, {(8 + ADDR_W){1'b0}}};
              o_mem_io_mode <= wr_q;
              o_mem_sio     <= wr_q ? i_req_data[DATA_W-1 -: 4] : 4'h0;
            end else begin
              state    <= END;
              o_mem_cs <= 1'b1;
              pend     <= 1'b1;
              wr_q     <= i_req_wr;
              sr       <= frame;
            end
          end
        end
        END: begin
          if (pend) begin
            pend          <= 1'b0;
            state         <= CMD;
            cnt           <= 8'd0;
            o_mem_cs      <= 1'b0;
            o_mem_io_mode <= 1'b1;
            o_mem_sio     <= sr[FW-1 -: 4];
          end else begin
            state     <= IDLE;
            o_req_rdy <= 1'b1;
          end
        end
`else
        END: begin
          state     <= IDLE;
          o_req_rdy <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed self-checking bench for idli_sqi_ctrl_m: a default-parameter instance plus a
// narrow instance (ADDR_W=16, DATA_W=8, DUMMY_NIB=0), each with a small nibble-returning memory model.
module tb_idli_sqi_ctrl_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vld, wr, cont;
  logic [23:0] addr;
  logic [15:0] data;
  logic        rdy, rd_vld, sck, cs, io;
  logic [15:0] rd_data;
  logic [3:0]  sio_o, sio_i;

  logic        vld2, wr2;
  logic [15:0] addr2;
  logic [7:0]  data2;
  logic        rdy2, rd_vld2, sck2, cs2, io2;
  logic [7:0]  rd2;
  logic [3:0]  sio2_o, sio2_i;

  int checks = 0;
  int errors = 0;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck(clk), .i_sqi_rst(rst), .i_req_vld(vld), .o_req_rdy(rdy),
    .i_req_wr(wr), .i_req_addr(addr), .i_req_data(data),
`ifdef IDLI_SQI_CTRL_BURST_EN
    .i_req_cont(cont),
`endif
    .o_rd_data(rd_data), .o_rd_vld(rd_vld), .o_mem_sck(sck), .o_mem_cs(cs),
    .o_mem_io_mode(io), .i_mem_sio(sio_i), .o_mem_sio(sio_o)
  );

  idli_sqi_ctrl_m #(.ADDR_W(16), .DATA_W(8), .DUMMY_NIB(0)) dut2 (
    .i_sqi_gck(clk), .i_sqi_rst(rst), .i_req_vld(vld2), .o_req_rdy(rdy2),
    .i_req_wr(wr2), .i_req_addr(addr2), .i_req_data(data2),
`ifdef IDLI_SQI_CTRL_BURST_EN
    .i_req_cont(1'b0),
`endif
    .o_rd_data(rd2), .o_rd_vld(rd_vld2), .o_mem_sck(sck2), .o_mem_cs(cs2),
    .o_mem_io_mode(io2), .i_mem_sio(sio2_i), .o_mem_sio(sio2_o)
  );

  // Memory models: drive the return nibble when SCK rises for a data slot.
  logic [15:0] ret1  = 16'hCAFE;
  logic [15:0] ret1b = 16'h1234;
  logic [7:0]  ret2  = 8'hA5;
  logic [15:0] mw;
  int slot1, slot2, mk;
  always @(negedge cs)  slot1 = 0;
  always @(negedge cs2) slot2 = 0;
  always @(posedge sck) begin
    if (slot1 >= 10) begin
      mk    = (slot1 - 10) % 4;
      mw    = ((slot1 - 10) / 4 == 0) ? ret1 : ret1b;
      sio_i = mw[(15 - 4 * mk) -: 4];
    end
    slot1++;
  end
  always @(posedge sck2) begin
    if (slot2 >= 6) sio2_i = ret2[(7 - 4 * ((slot2 - 6) % 2)) -: 4];
    slot2++;
  end

  // Bus monitors sampled on the falling clock edge.
  int cs_low, io1, pulses, falls, gap, vld_cyc, idle_viol;
  int cs_low2, pulses2, vld2_cyc;
  logic prev_sck = 1'b0, prev_cs = 1'b1, prev_sck2 = 1'b0;
  logic [3:0]  nib_q[$];
  logic        io_q[$];
  logic [15:0] rd_seen[$];
  always @(negedge clk) begin
    if (!cs) begin
      cs_low++;
      if (io) io1++;
    end
    if (sck && !prev_sck) begin
      pulses++;
      nib_q.push_back(sio_o);
      io_q.push_back(io);
    end
    if (!cs && prev_cs) falls++;
    if (cs && falls == 1) gap++;
    if (cs && (sck || sio_o != 4'h0)) idle_viol++;
    if (rd_vld) begin
      vld_cyc++;
      rd_seen.push_back(rd_data);
    end
    if (!cs2) cs_low2++;
    if (sck2 && !prev_sck2) pulses2++;
    if (rd_vld2) vld2_cyc++;
    prev_sck  = sck;
    prev_cs   = cs;
    prev_sck2 = sck2;
  end

  task automatic clear_mon();
    cs_low = 0; io1 = 0; pulses = 0; falls = 0; gap = 0; vld_cyc = 0; idle_viol = 0;
    cs_low2 = 0; pulses2 = 0; vld2_cyc = 0;
    nib_q.delete(); io_q.delete(); rd_seen.delete();
  endtask

  task automatic accept1(input logic w, input logic [23:0] a, input logic [15:0] d, input logic c);
    @(negedge clk);
    wr = w; addr = a; data = d; cont = c; vld = 1'b1;
    for (int i = 0; i < 200 && !rdy; i++) @(negedge clk);
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL accept_timeout: rdy=%0b required 1", rdy);
    end
    @(posedge clk);
    #1;
    vld = 1'b0; wr = ~w; addr = 24'hFFFFFF; data = 16'h0000;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL rdy_after_accept: got %0b required 0", rdy);
    end
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while (!(rdy && cs) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL idle_timeout: rdy=%0b cs=%0b required 1/1", rdy, cs);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; wr = 1'b0; cont = 1'b0; addr = '0; data = '0; sio_i = 4'h0;
    vld2 = 1'b0; wr2 = 1'b0; addr2 = '0; data2 = '0; sio2_i = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs, sck, io, sio_o, rd_vld, rd_data, rdy} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: cs=%0b sck=%0b io=%0b sio=%h vld=%0b rd=%h rdy=%0b required 1 0 0 0 0 0000 0",
               cs, sck, io, sio_o, rd_vld, rd_data, rdy);
    end
    checks++;
    if ({cs2, sck2, io2, rdy2} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs2: got %b required 1000", {cs2, sck2, io2, rdy2});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_reset: got %0b required 1", rdy);
    end
  endtask

  task automatic test_write();
    logic [47:0] got;
    clear_mon();
    accept1(1'b1, 24'h012345, 16'hBEEF, 1'b0);
    wait_idle1();
    got = '0;
    foreach (nib_q[i]) got = {got[43:0], nib_q[i]};
    checks++;
    if (pulses != 12 || got !== 48'h020123_45BEEF) begin
      errors++;
      $display("FAIL write_nibbles: pulses=%0d data=%h required 12 020123_45beef", pulses, got);
    end
    checks++;
    if (cs_low != 24) begin
      errors++;
      $display("FAIL write_cs_low: got %0d required 24", cs_low);
    end
    checks++;
    if (io1 != 24) begin
      errors++;
      $display("FAIL write_io_mode: io=1 cycles %0d required 24", io1);
    end
    checks++;
    if (idle_viol != 0 || vld_cyc != 0) begin
      errors++;
      $display("FAIL write_idle_bus: viol=%0d rd_vld cycles=%0d required 0 0", idle_viol, vld_cyc);
    end
  endtask

  task automatic test_read();
    clear_mon();
    accept1(1'b0, 24'h000010, 16'h0000, 1'b0);
    wait_idle1();
    checks++;
    if (rd_data !== 16'hCAFE) begin
      errors++;
      $display("FAIL read_data: got %h required cafe", rd_data);
    end
    checks++;
    if (vld_cyc != 1) begin
      errors++;
      $display("FAIL read_vld_pulse: cycles %0d required 1", vld_cyc);
    end
    checks++;
    if (cs_low != 28 || pulses != 14) begin
      errors++;
      $display("FAIL read_cs_low: cs_low=%0d pulses=%0d required 28 14", cs_low, pulses);
    end
    checks++;
    if (io1 != 16 || io_q.size() < 9 || io_q[7] !== 1'b1 || io_q[8] !== 1'b0) begin
      errors++;
      $display("FAIL read_io_mode: io=1 cycles %0d required 16, dummy start 0", io1);
    end
    checks++;
    if (nib_q.size() < 8 || {nib_q[0], nib_q[1], nib_q[7]} !== 12'h030) begin
      errors++;
      $display("FAIL read_cmd: got cmd/addr lsn nibbles wrong, required 0,3 and 0");
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] got, exp;
    int n;
    clear_mon();
    @(negedge clk);
    wr = 1'b1; addr = 24'h112233; data = 16'h1357; vld = 1'b1;
    for (int i = 0; i < 50 && !rdy; i++) @(negedge clk);
    @(posedge clk);
    #1;
    addr = 24'hABCDEF; data = 16'h5A5A;
    @(negedge clk);
    n = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200 || cs !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_ready: n=%0d cs=%0b required ready while cs=1", n, cs);
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    wait_idle1();
    got = '0;
    foreach (nib_q[i]) got = {got[91:0], nib_q[i]};
    exp = {8'h02, 24'h112233, 16'h1357, 8'h02, 24'hABCDEF, 16'h5A5A};
    checks++;
    if (pulses != 24 || got !== exp) begin
      errors++;
      $display("FAIL b2b_nibbles: pulses=%0d got %h required 24 %h", pulses, got, exp);
    end
    checks++;
    if (falls != 2 || gap < 1 || cs_low != 48) begin
      errors++;
      $display("FAIL b2b_cs: falls=%0d gap=%0d cs_low=%0d required 2 >=1 48", falls, gap, cs_low);
    end
  endtask

  task automatic test_reset_mid_addr();
    int n;
    clear_mon();
    accept1(1'b0, 24'h000010, 16'h0000, 1'b0);
    n = 0;
    while (pulses < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({cs, sck, io, rdy} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_addr: cs/sck/io/rdy=%b required 1000 (pulses %0d)", {cs, sck, io, rdy}, pulses);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rdy: got %0b required 1", rdy);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (vld_cyc != 0 || cs !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_no_vld: rd_vld cycles %0d cs=%0b required 0 1", vld_cyc, cs);
    end
  endtask

  task automatic test_narrow();
    int n;
    clear_mon();
    @(negedge clk);
    wr2 = 1'b0; addr2 = 16'h0040; vld2 = 1'b1;
    for (int i = 0; i < 50 && !rdy2; i++) @(negedge clk);
    @(posedge clk);
    #1;
    vld2 = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(rdy2 && cs2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (pulses2 != 8 || cs_low2 != 16) begin
      errors++;
      $display("FAIL narrow_frame: pulses=%0d cs_low=%0d required 8 16", pulses2, cs_low2);
    end
    checks++;
    if (rd2 !== 8'hA5 || vld2_cyc != 1) begin
      errors++;
      $display("FAIL narrow_read: data=%h vld cycles=%0d required a5 1", rd2, vld2_cyc);
    end
  endtask

`ifdef IDLI_SQI_CTRL_BURST_EN
  task automatic test_burst();
    int n;
    clear_mon();
    accept1(1'b0, 24'h000100, 16'h0000, 1'b1);
    n = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy, cs, sck} !== 3'b100) begin
      errors++;
      $display("FAIL burst_hold: rdy/cs/sck=%b required 100", {rdy, cs, sck});
    end
    accept1(1'b0, 24'h000000, 16'h0000, 1'b0);
    wait_idle1();
    checks++;
    if (falls != 1 || pulses != 18 || io1 != 16) begin
      errors++;
      $display("FAIL burst_frame: falls=%0d pulses=%0d io1=%0d required 1 18 16", falls, pulses, io1);
    end
    checks++;
    if (rd_seen.size() != 2 || rd_seen[0] !== 16'hCAFE || rd_seen[1] !== 16'h1234) begin
      errors++;
      $display("FAIL burst_data: count=%0d required 2 words cafe 1234", rd_seen.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_addr();
    test_narrow();
`ifdef IDLI_SQI_CTRL_BURST_EN
    test_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
